// File: rtl/lru_tracker_pkg.sv
// Shared types and defaults for the per-set true-LRU replacement tracker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lru_tracker_pkg;

   localparam int LRU_WAYS = 4;
   localparam int LRU_SETS = 8;

   // Index width for a count of n items, never narrower than one bit.
   function automatic int lru_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int LRU_WAY_W = lru_idx_w(LRU_WAYS);

   // Way index as seen by the cache controller.
   typedef logic [LRU_WAY_W-1:0] lru_way_t;

   // Recency-stack operation applied to a single set.
   typedef enum logic [1:0] {
      LRU_NONE  = 2'd0,
      LRU_TOUCH = 2'd1,
      LRU_INVAL = 2'd2
   } lru_op_e;

endpackage

// File: rtl/lru_order_update.sv
// Next recency stack of one set for a touch (to MRU) or inval (to LRU).
// Latency: purely combinational.
// Backpressure: none; a way not present in the stack leaves it unchanged.
module lru_order_update
   import lru_tracker_pkg::*;
#(
   parameter int WAYS  = LRU_WAYS,
   parameter int WAY_W = lru_idx_w(WAYS)
) (
   input  logic [WAYS-1:0][WAY_W-1:0] order_in,
   input  lru_op_e                    op,
   input  logic [WAY_W-1:0]           way,
   output logic [WAYS-1:0][WAY_W-1:0] order_out
);

   int   k;
   logic found;

   // Locate the way, then rotate the slice between it and the target end.
   always_comb begin
      order_out = order_in;
      k         = 0;
      found     = 1'b0;
      // An out-of-range way never matches, because the stack is a permutation.
      for (int p = 0; p < WAYS; p++) begin
         if (order_in[p] == way) begin
            k     = p;
            found = 1'b1;
         end
      end
      if (found) begin
         case (op)
            LRU_TOUCH: begin
               for (int p = 0; p < WAYS-1; p++) begin
                  if (p >= k) order_out[p] = order_in[p+1];
               end
               order_out[WAYS-1] = way;
            end
            LRU_INVAL: begin
               for (int p = 1; p < WAYS; p++) begin
                  if (p <= k) order_out[p] = order_in[p-1];
               end
               order_out[0] = way;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/lru_tracker.sv
// Per-set true-LRU tracker: touch promotes to MRU, inval demotes to LRU, victim = LRU.
// Latency: victim_way combinational from state; updates visible next cycle; conflict 1 cycle.
// Backpressure: none; one touch and one inval per cycle, same-set inval dropped and flagged.
module lru_tracker
   import lru_tracker_pkg::*;
#(
   parameter int WAYS  = LRU_WAYS,
   parameter int SETS  = LRU_SETS,
   parameter int WAY_W = lru_idx_w(WAYS),
   parameter int SET_W = lru_idx_w(SETS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             touch,
   input  logic [SET_W-1:0] touch_set,
   input  logic [WAY_W-1:0] touch_way,
   input  logic             inval,
   input  logic [SET_W-1:0] inval_set,
   input  logic [WAY_W-1:0] inval_way,
   input  logic [SET_W-1:0] query_set,
   output logic [WAY_W-1:0] victim_way,
   output logic             conflict
);

   typedef logic [WAYS-1:0][WAY_W-1:0] stack_t;

   // Identity order: way p sits at position p.
   function automatic stack_t reset_stack();
      stack_t r;
      for (int p = 0; p < WAYS; p++) r[p] = WAY_W'(p);
      return r;
   endfunction

   stack_t order_q [SETS];
   stack_t touch_cur, inval_cur;
   stack_t touch_next, inval_next;
   logic   touch_ok, inval_ok;
   logic   same_set;
   logic   touch_apply, inval_apply;

   // An op is live only when its set and way both address real storage.
   assign touch_ok    = touch && (32'(touch_set) < 32'(SETS)) && (32'(touch_way) < 32'(WAYS));
   assign inval_ok    = inval && (32'(inval_set) < 32'(SETS)) && (32'(inval_way) < 32'(WAYS));
   assign same_set    = touch_ok && inval_ok && (touch_set == inval_set);
   assign touch_apply = touch_ok;
   assign inval_apply = inval_ok && !same_set;

   // Fetch the current stacks of the touched and invalidated sets.
   always_comb begin
      touch_cur = reset_stack();
      inval_cur = reset_stack();
      for (int s = 0; s < SETS; s++) begin
         if (touch_set == SET_W'(s)) touch_cur = order_q[s];
         if (inval_set == SET_W'(s)) inval_cur = order_q[s];
      end
   end

   lru_order_update #(
      .WAYS  (WAYS),
      .WAY_W (WAY_W)
   ) u_touch_upd (
      .order_in  (touch_cur),
      .op        (touch_apply ? LRU_TOUCH : LRU_NONE),
      .way       (touch_way),
      .order_out (touch_next)
   );

   lru_order_update #(
      .WAYS  (WAYS),
      .WAY_W (WAY_W)
   ) u_inval_upd (
      .order_in  (inval_cur),
      .op        (inval_apply ? LRU_INVAL : LRU_NONE),
      .way       (inval_way),
      .order_out (inval_next)
   );

   // Write back the addressed stacks; a same-set collision keeps only the touch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SETS; s++) order_q[s] <= reset_stack();
         conflict <= 1'b0;
      end else begin
         for (int s = 0; s < SETS; s++) begin
            if (touch_apply && (touch_set == SET_W'(s)))
               order_q[s] <= touch_next;
            else if (inval_apply && (inval_set == SET_W'(s)))
               order_q[s] <= inval_next;
         end
         conflict <= same_set;
      end
   end

   // Victim is the LRU entry of the queried set; unmapped sets read as way 0.
   always_comb begin
      victim_way = '0;
      for (int s = 0; s < SETS; s++) begin
         if (query_set == SET_W'(s)) victim_way = order_q[s][0];
      end
   end

endmodule

// File: tb/tb_lru_tracker.sv
// Bench: a 4-way/8-set and a 3-way/6-set tracker on shared stimulus, checked against queue models.
// Latency: model advances on each rising edge; outputs compared on every falling edge.
// Backpressure: n/a.
module tb_lru_tracker;

   logic       clk;
   logic       rst_n;
   logic       touch;
   logic [2:0] touch_set;
   logic [1:0] touch_way;
   logic       inval;
   logic [2:0] inval_set;
   logic [1:0] inval_way;
   logic [2:0] query_set;
   logic [1:0] victim4, victim3;
   logic       conflict4, conflict3;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   localparam int W [2] = '{4, 3};
   localparam int S [2] = '{8, 6};

   // Recency list per design per set: front = LRU, back = MRU.
   int mdl [2][8][$];
   bit exp_conf [2];

   lru_tracker #(.WAYS(4), .SETS(8)) d4 (
      .clk(clk), .rst_n(rst_n),
      .touch(touch), .touch_set(touch_set), .touch_way(touch_way),
      .inval(inval), .inval_set(inval_set), .inval_way(inval_way),
      .query_set(query_set), .victim_way(victim4), .conflict(conflict4)
   );

   lru_tracker #(.WAYS(3), .SETS(6)) d3 (
      .clk(clk), .rst_n(rst_n),
      .touch(touch), .touch_set(touch_set), .touch_way(touch_way),
      .inval(inval), .inval_set(inval_set), .inval_way(inval_way),
      .query_set(query_set), .victim_way(victim3), .conflict(conflict3)
   );

   initial begin
      clk = 1'b0;
      forever #20 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int find_pos(input int d, input int s, input int w);
      for (int i = 0; i < mdl[d][s].size(); i++)
         if (mdl[d][s][i] == w) return i;
      return -1;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int s = 0; s < 8; s++) begin
            mdl[d][s].delete();
            for (int w = 0; w < W[d]; w++) mdl[d][s].push_back(w);
         end
         exp_conf[d] = 1'b0;
      end
   endtask

   task automatic model_step();
      for (int d = 0; d < 2; d++) begin
         bit tok, iok, same;
         int idx, ts, is, tw, iw;
         ts   = int'(touch_set);
         is   = int'(inval_set);
         tw   = int'(touch_way);
         iw   = int'(inval_way);
         tok  = touch && (ts < S[d]) && (tw < W[d]);
         iok  = inval && (is < S[d]) && (iw < W[d]);
         same = tok && iok && (ts == is);
         if (tok) begin
            idx = find_pos(d, ts, tw);
            mdl[d][ts].delete(idx);
            mdl[d][ts].push_back(tw);
         end
         if (iok && !same) begin
            idx = find_pos(d, is, iw);
            mdl[d][is].delete(idx);
            mdl[d][is].push_front(iw);
         end
         exp_conf[d] = same;
      end
   endtask

   // One clock: DUT and model both take the current inputs, then inputs go idle.
   task automatic cyc();
      @(posedge clk);
      model_step();
      #2;
      touch = 1'b0;
      inval = 1'b0;
   endtask

   task automatic op(input bit t, input int ts, input int tw,
                     input bit i, input int is, input int iw);
      touch     = t;
      touch_set = 3'(ts);
      touch_way = 2'(tw);
      inval     = i;
      inval_set = 3'(is);
      inval_way = 2'(iw);
      cyc();
   endtask

   // Every falling edge: outputs and full stacks against the model, plus permutation.
   always @(negedge clk) begin
      if (chk_en) begin
         int q, e, nbad, nperm;
         bit [3:0] seen;
         q = int'(query_set);
         e = (q < 8) ? mdl[0][q][0] : 0;
         chk("victim4", int'(victim4), e);
         e = (q < 6) ? mdl[1][q][0] : 0;
         chk("victim3", int'(victim3), e);
         chk("conflict4", int'(conflict4), int'(exp_conf[0]));
         chk("conflict3", int'(conflict3), int'(exp_conf[1]));
         nbad = 0; nperm = 0;
         for (int s = 0; s < 8; s++) begin
            seen = '0;
            for (int p = 0; p < 4; p++) begin
               if (int'(d4.order_q[s][p]) != mdl[0][s][p]) nbad++;
               seen[d4.order_q[s][p]] = 1'b1;
            end
            if (seen != 4'b1111) nperm++;
         end
         chk("stack4_diff", nbad, 0);
         chk("perm4_bad", nperm, 0);
         nbad = 0; nperm = 0;
         for (int s = 0; s < 6; s++) begin
            seen = '0;
            for (int p = 0; p < 3; p++) begin
               if (int'(d3.order_q[s][p]) != mdl[1][s][p]) nbad++;
               seen[d3.order_q[s][p]] = 1'b1;
            end
            if (seen != 4'b0111) nperm++;
         end
         chk("stack3_diff", nbad, 0);
         chk("perm3_bad", nperm, 0);
      end
   end

   initial begin
      rst_n = 1'b0;
      touch = 1'b0; touch_set = '0; touch_way = '0;
      inval = 1'b0; inval_set = '0; inval_way = '0;
      query_set = '0;
      model_reset();
      #30;
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // Reset state: every set reports way 0, no conflict.
      for (int q = 0; q < 8; q++) begin
         query_set = 3'(q);
         #1;
         chk("rst_victim4", int'(victim4), 0);
         chk("rst_victim3", int'(victim3), 0);
      end
      chk("rst_conflict4", int'(conflict4), 0);

      // Set 2: touch 0..3 keeps identity order, then touches rotate the victim.
      query_set = 3'd2;
      for (int w = 0; w < 4; w++) op(1, 2, w, 0, 0, 0);
      chk("t2_victim_a", int'(victim4), 0);
      op(1, 2, 0, 0, 0, 0);
      chk("t2_victim_b", int'(victim4), 1);
      op(1, 2, 1, 0, 0, 0);
      chk("t2_victim_c", int'(victim4), 2);
      query_set = 3'd0;
      #1 chk("t2_other_set", int'(victim4), 0);

      // Set 5: inval way 2 -> (2,0,1,3); repeat leaves it unchanged.
      query_set = 3'd5;
      op(0, 0, 0, 1, 5, 2);
      chk("t3_victim_a", int'(victim4), 2);
      op(0, 0, 0, 1, 5, 2);
      chk("t3_victim_b", int'(victim4), 2);

      // Set 3 collision: touch wins -> (1,2,3,0), conflict pulses for one cycle.
      query_set = 3'd3;
      op(1, 3, 0, 1, 3, 1);
      chk("t4_victim", int'(victim4), 1);
      chk("t4_conflict_hi", int'(conflict4), 1);
      cyc();
      chk("t4_conflict_lo", int'(conflict4), 0);

      // Different sets in one cycle: both apply; query sees pre-update value first.
      query_set = 3'd1;
      touch = 1'b1; touch_set = 3'd1; touch_way = 2'd0;
      inval = 1'b1; inval_set = 3'd4; inval_way = 2'd3;
      #1 chk("t5_pre_victim", int'(victim4), 0);
      cyc();
      chk("t5_post_victim", int'(victim4), 1);
      chk("t5_conflict", int'(conflict4), 0);
      query_set = 3'd4;
      #1 chk("t5_inval_victim", int'(victim4), 3);

      // Three-way design: way 3 is out of range and must be ignored.
      query_set = 3'd0;
      op(1, 0, 0, 0, 0, 0);
      chk("t6_victim3_a", int'(victim3), 1);
      op(1, 0, 3, 0, 0, 0);
      chk("t6_victim3_b", int'(victim3), 1);
      op(0, 0, 0, 1, 1, 3);
      // Bad touch way beside a good inval on the same set: inval applies, no conflict.
      query_set = 3'd2;
      op(1, 2, 3, 1, 2, 1);
      chk("t6_victim3_c", int'(victim3), 1);
      chk("t6_conflict3", int'(conflict3), 0);
      chk("t6_conflict4", int'(conflict4), 1);
      // Set 6 exists only in the 8-set design.
      query_set = 3'd6;
      op(1, 6, 0, 0, 0, 0);
      chk("t6_set6_v4", int'(victim4), 1);
      chk("t6_set6_v3", int'(victim3), 0);

      // Mixed traffic against the model.
      for (int n = 0; n < 60; n++) begin
         query_set = 3'($urandom_range(0, 7));
         op(bit'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 3),
            bit'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 3));
      end

      // Reset mid-operation: stacks return to identity with no clock edge.
      touch = 1'b1; touch_set = 3'd0; touch_way = 2'd0;
      inval = 1'b1; inval_set = 3'd1; inval_way = 2'd2;
      rst_n = 1'b0;
      model_reset();
      for (int q = 0; q < 8; q++) begin
         query_set = 3'(q);
         #1;
         chk("mrst_victim4", int'(victim4), 0);
         chk("mrst_victim3", int'(victim3), 0);
      end
      chk("mrst_conflict4", int'(conflict4), 0);
      @(posedge clk);
      #2;
      touch = 1'b0;
      inval = 1'b0;
      rst_n = 1'b1;
      query_set = 3'd0;
      op(1, 0, 0, 0, 0, 0);
      chk("post_rst_victim4", int'(victim4), 1);
      op(0, 0, 0, 1, 0, 3);
      chk("post_rst_victim4_b", int'(victim4), 3);
      cyc();

      @(negedge clk);
      #1;
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
